// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite encodings and master index type
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  typedef logic mst_idx_t;

  // Two-master one-hot grant to index: bit 1 set means master 1.
  function automatic mst_idx_t onehot_to_idx(input logic [1:0] oh);
    return oh[1];
  endfunction

  function automatic logic [1:0] idx_to_onehot(input mst_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ahb_arb_rr2.sv
// rtl/ahb_arb_rr2.sv - two-master round-robin grant, tenure and lock tracking
module ahb_arb_rr2
  import ahb_pkg::*;
#(
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_TENURE     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hready,
  input  logic [1:0] hbusreq,
  input  logic [1:0] hlock,
  input  logic [1:0] htrans_m0,
  input  logic [1:0] htrans_m1,
  output logic [1:0] grant,
  output mst_idx_t   hmaster,
  output logic       mastlock
);

  localparam int             TW        = $clog2(MAX_TENURE + 1);
  localparam logic [TW-1:0]  TEN_MAX   = TW'(MAX_TENURE);
  localparam mst_idx_t       DEF_IDX   = (DEFAULT_MASTER != 0);
  localparam logic [1:0]     DEF_GRANT = DEF_IDX ? 2'b10 : 2'b01;

  logic [1:0]    grant_q, grant_d;
  mst_idx_t      hmaster_q, hmaster_d;
  logic          lock_q, lock_d;
  logic [TW-1:0] tenure_q, tenure_d;

  mst_idx_t      own, other, next_idx;
  logic [1:0]    own_trans;
  logic          own_req, other_req, hold, own_active;

  // Next-grant decision and tenure accounting; everything holds while HREADY is low.
  always_comb begin
    own        = onehot_to_idx(grant_q);
    other      = ~own;
    own_req    = hbusreq[own];
    other_req  = hbusreq[other];
    own_trans  = own ? htrans_m1 : htrans_m0;
    own_active = (own_trans == HTRANS_NONSEQ) || (own_trans == HTRANS_SEQ);
    // Locked request, an in-flight burst, or a locked data phase still retiring pin the owner.
    hold       = (hlock[own] & own_req)
               | ((own_trans == HTRANS_SEQ) && (hmaster_q == own))
               | lock_q;

    if (hold)                                        next_idx = own;
    else if (other_req && (!own_req || tenure_q >= TEN_MAX)) next_idx = other;
    else if (own_req)                                next_idx = own;
    else                                             next_idx = DEF_IDX;

    grant_d   = grant_q;
    hmaster_d = hmaster_q;
    lock_d    = lock_q;
    tenure_d  = tenure_q;
    if (hready) begin
      grant_d   = idx_to_onehot(next_idx);
      hmaster_d = own;
      lock_d    = hlock[own];
      if (next_idx != own)
        tenure_d = '0;
      else if ((hmaster_q == own) && own_active && other_req && (tenure_q != TEN_MAX))
        tenure_d = tenure_q + TW'(1);
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q   <= DEF_GRANT;
      hmaster_q <= DEF_IDX;
      lock_q    <= 1'b0;
      tenure_q  <= '0;
    end else begin
      grant_q   <= grant_d;
      hmaster_q <= hmaster_d;
      lock_q    <= lock_d;
      tenure_q  <= tenure_d;
    end
  end

  assign grant    = grant_q;
  assign hmaster  = hmaster_q;
  assign mastlock = lock_q;

endmodule

// File: rtl/ahb_arbiter_2m.sv
// rtl/ahb_arbiter_2m.sv - two-master AHB-Lite arbiter and bus multiplexer
module ahb_arbiter_2m
  import ahb_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_TENURE     = 16
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HBUSREQ_M0,
  input  logic          HBUSREQ_M1,
  input  logic          HLOCK_M0,
  input  logic          HLOCK_M1,
  output logic          HGRANT_M0,
  output logic          HGRANT_M1,
  input  logic [AW-1:0] HADDR_M0,
  input  logic [AW-1:0] HADDR_M1,
  input  logic [1:0]    HTRANS_M0,
  input  logic [1:0]    HTRANS_M1,
  input  logic          HWRITE_M0,
  input  logic          HWRITE_M1,
  input  logic [2:0]    HSIZE_M0,
  input  logic [2:0]    HSIZE_M1,
  input  logic [DW-1:0] HWDATA_M0,
  input  logic [DW-1:0] HWDATA_M1,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [DW-1:0] HWDATA,
  input  logic          HREADY,
  input  logic [DW-1:0] HRDATA,
  output logic          HREADY_M0,
  output logic          HREADY_M1,
  output logic [DW-1:0] HRDATA_M0,
  output logic [DW-1:0] HRDATA_M1,
  output logic          HMASTER,
  output logic          HMASTLOCK
);

  localparam mst_idx_t DEF_IDX = (DEFAULT_MASTER != 0);

  logic [1:0] grant;
  mst_idx_t   addr_owner;
  mst_idx_t   data_owner_q, data_owner_d;

  ahb_arb_rr2 #(
    .DEFAULT_MASTER (DEFAULT_MASTER),
    .MAX_TENURE     (MAX_TENURE)
  ) u_arb (
    .clk       (HCLK),
    .rst       (HRESET),
    .hready    (HREADY),
    .hbusreq   ({HBUSREQ_M1, HBUSREQ_M0}),
    .hlock     ({HLOCK_M1, HLOCK_M0}),
    .htrans_m0 (HTRANS_M0),
    .htrans_m1 (HTRANS_M1),
    .grant     (grant),
    .hmaster   (addr_owner),
    .mastlock  (HMASTLOCK)
  );

  // Data-phase owner trails the address-phase owner by one completed transfer.
  always_comb begin
    data_owner_d = data_owner_q;
    if (HREADY) data_owner_d = addr_owner;
  end

  // Data-phase owner register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) data_owner_q <= DEF_IDX;
    else        data_owner_q <= data_owner_d;
  end

  assign HGRANT_M0 = grant[0];
  assign HGRANT_M1 = grant[1];
  assign HMASTER   = addr_owner;

  assign HADDR  = addr_owner ? HADDR_M1  : HADDR_M0;
  assign HTRANS = addr_owner ? HTRANS_M1 : HTRANS_M0;
  assign HWRITE = addr_owner ? HWRITE_M1 : HWRITE_M0;
  assign HSIZE  = addr_owner ? HSIZE_M1  : HSIZE_M0;
  assign HWDATA = data_owner_q ? HWDATA_M1 : HWDATA_M0;

  assign HREADY_M0 = HREADY;
  assign HREADY_M1 = HREADY;
  assign HRDATA_M0 = HRDATA;
  assign HRDATA_M1 = HRDATA;

endmodule

// File: tb/tb_ahb_arbiter_2m.sv
// tb/tb_ahb_arbiter_2m.sv - self-checking bench for ahb_arbiter_2m
module tb_ahb_arbiter_2m;

  localparam int MAXT = 4;
  localparam logic [31:0] A0 = 32'h2000_0000;
  localparam logic [31:0] A1 = 32'h4000_0000;
  localparam logic [31:0] W0 = 32'h1111_1111;
  localparam logic [31:0] W1 = 32'hDEAD_BEEF;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HBUSREQ_M0 = 0, HBUSREQ_M1 = 0, HLOCK_M0 = 0, HLOCK_M1 = 0;
  logic        HGRANT_M0, HGRANT_M1;
  logic [31:0] HADDR_M0 = A0, HADDR_M1 = A1;
  logic [1:0]  HTRANS_M0 = 0, HTRANS_M1 = 0;
  logic        HWRITE_M0 = 0, HWRITE_M1 = 1;
  logic [2:0]  HSIZE_M0 = 3'b010, HSIZE_M1 = 3'b001;
  logic [31:0] HWDATA_M0 = W0, HWDATA_M1 = W1;
  logic [31:0] HADDR, HWDATA, HRDATA = 32'h0, HRDATA_M0, HRDATA_M1;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY = 1, HREADY_M0, HREADY_M1, HMASTER, HMASTLOCK;
  logic [2:0]  HSIZE;

  int tests = 0;
  int fails = 0;

  ahb_arbiter_2m #(.AW(32), .DW(32), .DEFAULT_MASTER(0), .MAX_TENURE(MAXT)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HBUSREQ_M0(HBUSREQ_M0), .HBUSREQ_M1(HBUSREQ_M1),
    .HLOCK_M0(HLOCK_M0), .HLOCK_M1(HLOCK_M1),
    .HGRANT_M0(HGRANT_M0), .HGRANT_M1(HGRANT_M1),
    .HADDR_M0(HADDR_M0), .HADDR_M1(HADDR_M1),
    .HTRANS_M0(HTRANS_M0), .HTRANS_M1(HTRANS_M1),
    .HWRITE_M0(HWRITE_M0), .HWRITE_M1(HWRITE_M1),
    .HSIZE_M0(HSIZE_M0), .HSIZE_M1(HSIZE_M1),
    .HWDATA_M0(HWDATA_M0), .HWDATA_M1(HWDATA_M1),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA),
    .HREADY_M0(HREADY_M0), .HREADY_M1(HREADY_M1),
    .HRDATA_M0(HRDATA_M0), .HRDATA_M1(HRDATA_M1),
    .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    HBUSREQ_M0 = 0; HBUSREQ_M1 = 0; HLOCK_M0 = 0; HLOCK_M1 = 0;
    HTRANS_M0 = 0; HTRANS_M1 = 0; HREADY = 1;
    HADDR_M0 = A0; HADDR_M1 = A1; HWDATA_M0 = W0; HWDATA_M1 = W1;
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  typedef struct {
    logic [1:0] req;
    logic [1:0] tr0;
    logic [1:0] tr1;
    logic [1:0] eg;
    logic       eh;
    logic       ew;
  } vec_t;

  vec_t tbl[14];

  // Behavioural reference: who owns what, expressed as plain integers.
  int m_grant, m_addr, m_data, m_lock, m_ten;

  task automatic model_step();
    int req[2], lk[2], tr[2];
    int own, oth, nxt;
    bit hold;
    req[0] = HBUSREQ_M0; req[1] = HBUSREQ_M1;
    lk[0]  = HLOCK_M0;   lk[1]  = HLOCK_M1;
    tr[0]  = HTRANS_M0;  tr[1]  = HTRANS_M1;
    if (!HREADY) return;
    own  = m_grant;
    oth  = 1 - own;
    hold = (lk[own] && req[own]) || (tr[own] == 3 && m_addr == own) || (m_lock != 0);
    if (hold) nxt = own;
    else if (req[oth] && (!req[own] || m_ten >= MAXT)) nxt = oth;
    else if (req[own]) nxt = own;
    else nxt = 0;
    if (nxt != own) m_ten = 0;
    else if (m_addr == own && tr[own] >= 2 && req[oth]) m_ten = (m_ten + 1 > MAXT) ? MAXT : m_ten + 1;
    m_data  = m_addr;
    m_addr  = own;
    m_lock  = lk[own];
    m_grant = nxt;
  endtask

  initial begin
    // Handover then round-robin with tenure of 4 completed transfers per owner.
    tbl[0] = '{2'b10, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0};
    tbl[1] = '{2'b10, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0};
    tbl[2] = '{2'b10, 2'b00, 2'b10, 2'b10, 1'b1, 1'b1};
    for (int i = 3; i <= 6; i++) tbl[i] = '{2'b11, 2'b10, 2'b10, 2'b10, 1'b1, 1'b1};
    tbl[7] = '{2'b11, 2'b10, 2'b10, 2'b01, 1'b1, 1'b1};
    tbl[8] = '{2'b11, 2'b10, 2'b10, 2'b01, 1'b0, 1'b1};
    for (int i = 9; i <= 12; i++) tbl[i] = '{2'b11, 2'b10, 2'b10, 2'b01, 1'b0, 1'b0};
    tbl[13] = '{2'b11, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0};

    do_reset();
    #1;
    check("rst_grant", {HGRANT_M1, HGRANT_M0}, 2'b01);
    check("rst_hmaster", HMASTER, 0);
    check("rst_mastlock", HMASTLOCK, 0);
    check("rst_haddr", HADDR, A0);
    check("rst_hwdata", HWDATA, W0);

    for (int i = 0; i < 14; i++) begin
      @(negedge HCLK);
      HBUSREQ_M0 = tbl[i].req[0]; HBUSREQ_M1 = tbl[i].req[1];
      HTRANS_M0 = tbl[i].tr0; HTRANS_M1 = tbl[i].tr1;
      @(posedge HCLK); #1;
      check($sformatf("vec%0d_grant", i), {HGRANT_M1, HGRANT_M0}, tbl[i].eg);
      check($sformatf("vec%0d_hmaster", i), HMASTER, tbl[i].eh);
      check($sformatf("vec%0d_haddr", i), HADDR, tbl[i].eh ? A1 : A0);
      check($sformatf("vec%0d_hwdata", i), HWDATA, tbl[i].ew ? W1 : W0);
      check($sformatf("vec%0d_mastlock", i), HMASTLOCK, 0);
    end

    // Locked sequence from M0 while M1 requests.
    do_reset();
    HBUSREQ_M0 = 1; HBUSREQ_M1 = 1; HLOCK_M0 = 1; HTRANS_M0 = 2'b10; HTRANS_M1 = 2'b10;
    for (int i = 0; i < 10; i++) begin
      @(posedge HCLK); #1;
      check("lock_grant", {HGRANT_M1, HGRANT_M0}, 2'b01);
      check("lock_mastlock", HMASTLOCK, 1);
    end
    @(negedge HCLK);
    HLOCK_M0 = 0; HBUSREQ_M0 = 0; HTRANS_M0 = 2'b00;
    @(posedge HCLK); #1;
    check("lock_tail_grant", {HGRANT_M1, HGRANT_M0}, 2'b01);
    check("lock_tail_mastlock", HMASTLOCK, 0);
    @(posedge HCLK); #1;
    check("lock_release_grant", {HGRANT_M1, HGRANT_M0}, 2'b10);

    // M1 burst with an HREADY stall while M0 requests.
    do_reset();
    HBUSREQ_M1 = 1; HTRANS_M1 = 2'b10;
    @(posedge HCLK); @(posedge HCLK); #1;
    check("burst_own_grant", {HGRANT_M1, HGRANT_M0}, 2'b10);
    check("burst_own_hmaster", HMASTER, 1);
    @(negedge HCLK); HBUSREQ_M0 = 1; HTRANS_M0 = 2'b10;
    @(posedge HCLK); #1;
    check("burst_b1_grant", {HGRANT_M1, HGRANT_M0}, 2'b10);
    @(negedge HCLK); HTRANS_M1 = 2'b11;
    @(posedge HCLK); #1;
    check("burst_b2_grant", {HGRANT_M1, HGRANT_M0}, 2'b10);
    @(negedge HCLK); HREADY = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge HCLK); #1;
      check("stall_grant", {HGRANT_M1, HGRANT_M0}, 2'b10);
      check("stall_hmaster", HMASTER, 1);
      check("stall_hwdata", HWDATA, W1);
    end
    @(negedge HCLK); HREADY = 1;
    @(posedge HCLK); #1;
    check("burst_b3_grant", {HGRANT_M1, HGRANT_M0}, 2'b10);
    @(posedge HCLK); #1;
    check("burst_b4_grant", {HGRANT_M1, HGRANT_M0}, 2'b10);
    @(negedge HCLK); HTRANS_M1 = 2'b00; HBUSREQ_M1 = 0;
    @(posedge HCLK); #1;
    check("burst_end_grant", {HGRANT_M1, HGRANT_M0}, 2'b01);

    // Asynchronous reset in the middle of a locked M1 sequence.
    @(negedge HCLK); HBUSREQ_M0 = 0; HTRANS_M0 = 0; HBUSREQ_M1 = 1; HLOCK_M1 = 1; HTRANS_M1 = 2'b10;
    repeat (3) @(posedge HCLK);
    #1;
    check("pre_arst_mastlock", HMASTLOCK, 1);
    check("pre_arst_hwdata", HWDATA, W1);
    #2 HRESET = 1;
    #1;
    check("arst_grant", {HGRANT_M1, HGRANT_M0}, 2'b01);
    check("arst_hmaster", HMASTER, 0);
    check("arst_mastlock", HMASTLOCK, 0);
    check("arst_haddr", HADDR, A0);
    check("arst_hwdata", HWDATA, W0);

    // Randomized traffic against the reference model.
    do_reset();
    m_grant = 0; m_addr = 0; m_data = 0; m_lock = 0; m_ten = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge HCLK);
      HBUSREQ_M0 = ($urandom_range(0, 3) != 0);
      HBUSREQ_M1 = ($urandom_range(0, 3) != 0);
      HLOCK_M0 = ($urandom_range(0, 9) == 0);
      HLOCK_M1 = ($urandom_range(0, 9) == 0);
      HTRANS_M0 = 2'($urandom); HTRANS_M1 = 2'($urandom);
      HWRITE_M0 = 1'($urandom); HWRITE_M1 = 1'($urandom);
      HSIZE_M0 = 3'($urandom_range(0, 2)); HSIZE_M1 = 3'($urandom_range(0, 2));
      HADDR_M0 = $urandom; HADDR_M1 = $urandom;
      HWDATA_M0 = $urandom; HWDATA_M1 = $urandom;
      HRDATA = $urandom;
      HREADY = ($urandom_range(0, 3) != 0);
      #1;
      check("rnd_grant", {HGRANT_M1, HGRANT_M0}, (m_grant == 1) ? 2'b10 : 2'b01);
      check("rnd_hmaster", HMASTER, m_addr);
      check("rnd_mastlock", HMASTLOCK, m_lock);
      check("rnd_addr_ctl", {HADDR, HTRANS, HWRITE, HSIZE},
            m_addr ? {HADDR_M1, HTRANS_M1, HWRITE_M1, HSIZE_M1} : {HADDR_M0, HTRANS_M0, HWRITE_M0, HSIZE_M0});
      check("rnd_hwdata", HWDATA, m_data ? HWDATA_M1 : HWDATA_M0);
      check("rnd_fanout", {HREADY_M0, HREADY_M1, HRDATA_M0, HRDATA_M1}, {HREADY, HREADY, HRDATA, HRDATA});
      @(posedge HCLK);
      model_step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter_2m.md
Name: ahb_arbiter_2m

Overview:
- Two-master AHB-Lite arbiter/multiplexer placed between the masters and the AHBlite_sys_0 slave fabric.
- Master 0 is the IBEX_wrapper. Master 1 is a future DMA/debug master.
- Replaces the tied-off HBUSREQ/HGRANT pair: decides which master drives the shared address/control and write-data buses, and returns HREADY/HRDATA to both.
- Round-robin arbitration, with bus-lock support and a tenure limit.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- DEFAULT_MASTER, 0, master granted when nobody requests, and at reset.
- MAX_TENURE, 16, completed transfers a master may own the bus while the other requests, before forced re-arbitration (unlocked only). Must be ≥1.

Ports:
- HCLK  in  1  system clock
- HRESET  in  1  asynchronous active-high reset
- HBUSREQ_M0, HBUSREQ_M1  in  1  bus request
- HLOCK_M0, HLOCK_M1  in  1  locked-sequence request
- HGRANT_M0, HGRANT_M1  out  1  grant
- HADDR_M0, HADDR_M1  in  AW  master address
- HTRANS_M0, HTRANS_M1  in  2  master transfer type
- HWRITE_M0, HWRITE_M1  in  1  master write
- HSIZE_M0, HSIZE_M1  in  3  master size
- HWDATA_M0, HWDATA_M1  in  DW  master write data
- HADDR  out  AW  muxed address to fabric
- HTRANS  out  2  muxed transfer type
- HWRITE  out  1  muxed write
- HSIZE  out  3  muxed size
- HWDATA  out  DW  muxed write data
- HREADY  in  1  fabric ready; also fanned out to both masters
- HRDATA  in  DW  fabric read data; also fanned out to both masters
- HMASTER  out  1  current address-phase owner
- HMASTLOCK  out  1  owner's locked transfer indicator

Behaviour:
- All state updates on the HCLK rising edge, only when HREADY=1. When HREADY=0, all registers hold.
- Registers:
  - grant_r: one-hot, 2 bits.
  - hmaster_r: address-phase owner.
  - hmaster_d: data-phase owner.
  - lock_r.
  - tenure_cnt: width $clog2(MAX_TENURE+1).
- Reset (async, HRESET=1):
  - grant_r = onehot(DEFAULT_MASTER); hmaster_r = hmaster_d = DEFAULT_MASTER.
  - lock_r = 0; tenure_cnt = 0.
  - HGRANT_M[DEFAULT_MASTER]=1, the other 0.
  - HMASTER = DEFAULT_MASTER; HMASTLOCK = 0.
  - Muxed outputs follow the DEFAULT_MASTER inputs.
- Outputs:
  - HGRANT_Mx = grant_r[x], driven directly from the register.
  - HADDR/HTRANS/HWRITE/HSIZE are muxed by hmaster_r.
  - HWDATA is muxed by hmaster_d.
  - HMASTER = hmaster_r; HMASTLOCK = lock_r.
- Pipeline, on each edge with HREADY=1:
  - hmaster_d <= hmaster_r.
  - hmaster_r <= index(grant_r).
  - lock_r <= HLOCK of the granted master.
  - Result: a grant change takes effect on the address bus one transfer later; write data follows one transfer after that.
- Arbitration (computes the next grant_r when HREADY=1). Let own = index(grant_r) and other = !own.
  - HOLD if any of these is true:
    - HLOCK_own=1 and HBUSREQ_own=1;
    - HTRANS_own==SEQ(2'b11) and hmaster_r==own (mid-burst);
    - lock_r=1 (locked data phase completing).
  - Otherwise, if HBUSREQ_other=1 and (HBUSREQ_own=0 or tenure_cnt≥MAX_TENURE): grant other.
  - Otherwise, if HBUSREQ_own=1: keep own.
  - Otherwise (neither requests): grant DEFAULT_MASTER.
  - Simultaneous first requests from both masters while DEFAULT_MASTER is parked: DEFAULT_MASTER keeps the bus. Round-robin applies from the next decision.
- Tenure counter:
  - Reset to 0 whenever the grant changes.
  - Increments, saturating at MAX_TENURE, on each HREADY=1 edge where hmaster_r==own, HTRANS is NONSEQ or SEQ, and HBUSREQ_other=1.
  - Otherwise holds.
- Lock: tenure expiry is ignored while the hold conditions apply. A locked master can starve the other indefinitely; this is by design.
- IDLE/BUSY transfers from the owner count as no transfer for tenure purposes.
- Reset asserted mid-transfer: immediate return to the reset state; muxes revert combinationally.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS encodings IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11;
  - HSIZE encodings;
  - the master index type.
- One sub-module, ahb_arb_rr2: grant/tenure/lock logic, producing grant_r and hmaster_r.
- The top level holds hmaster_d and the muxes.

Test Plan:
- Reset → HGRANT_M0=1, HGRANT_M1=0, HMASTER=0, HMASTLOCK=0. Outputs mirror M0 inputs (e.g. HADDR_M0=32'h2000_0000 appears on HADDR).
- M0 idle with HBUSREQ_M0=0, M1 requests, HREADY=1 → HGRANT_M1=1 after 1 edge; HMASTER=1 after 2 edges; M1 write HWDATA_M1=32'hDEADBEEF appears on HWDATA after 3 edges.
- Both request continuously, unlocked NONSEQ singles, MAX_TENURE=4 → grant alternates every 4 completed transfers; tenure_cnt saturates and resets on switch.
- M0 asserts HLOCK_M0=1 with 10 transfers while M1 requests → no grant change during the lock; HMASTLOCK=1 during those address phases; M1 granted the first edge after HLOCK_M0 drops and the last locked data phase completes.
- HREADY=0 for 5 cycles during an M1 4-beat INCR burst, with M0 requesting → grant, HMASTER and HWDATA select held; no switch on SEQ beats; switch only after the burst's last beat.
- HRESET pulsed asynchronously mid-burst → outputs return to reset values without a clock edge.
